led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 12500000, clk cycles per pattern step (4 Hz at 50 MHz); legal range >= 2.
REQ-002 Parameter NLED, default 6, number of LED outputs; legal range 2..32.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  level enable; 1 = advance pattern, 0 = hold.
REQ-006 stop  input  1  one-cycle pulse; return to IDLE.
REQ-007 mode_req  input  1  mode load request; accepted on rising edge only.
REQ-008 mode_sel  input  2  requested mode, sampled in the accepting cycle: 0 ALL_BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT.
REQ-009 mode_ack  output  1  one-cycle pulse acknowledging an accepted mode_req.
REQ-010 led  output  NLED  registered LED drive; bit 0 = LED0.
REQ-011 step_tick  output  1  one-cycle pulse, high in the first cycle a new stepped pattern is on led.
REQ-012 busy  output  1  1 when state != IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, HOLD.
REQ-014 Transitions: IDLE->RUN when run=1; RUN->HOLD when run=0; HOLD->RUN when run=1; any state->IDLE when stop=1.
REQ-015 Event priority: rst > stop > mode load > run/tick; stop in the same cycle as mode_req suppresses the load and mode_ack.
REQ-016 A mode_req rising edge is mode_req=1 while the previous-cycle sample is 0; holding mode_req high SHALL produce one ack only.
REQ-017 An accepted request: mode_sel is stored at the edge; mode_ack=1 in the following cycle only.
REQ-018 Mode load in RUN/HOLD: led loads the new mode's start pattern, prescaler clears to 0, BOUNCE direction is set up, state unchanged, no step_tick.
REQ-019 Mode load in IDLE: only the stored mode changes; led stays 0. If it coincides with IDLE->RUN, the new mode's start pattern is used.
REQ-020 Start patterns: ALL_BLINK all ones; CHASE 1; BOUNCE 1 (direction up); COUNT 0.
REQ-021 In IDLE: led=0, prescaler=0. On IDLE->RUN, led loads the start pattern at the transition edge with prescaler=0.
REQ-022 Prescaler: width clog2(TICK_DIV); counts only in RUN; wraps TICK_DIV-1 -> 0. The wrap edge is the step edge.
REQ-023 At a step edge led advances; step_tick=1 in the next cycle only. The step period is exactly TICK_DIV cycles.
REQ-024 ALL_BLINK step: led = ~led (all ones / all zeros).
REQ-025 CHASE step: rotate left; bit NLED-1 wraps to bit 0.
REQ-026 BOUNCE step: single lit bit moves toward MSB while up and toward LSB while down. Direction flips on reaching bit NLED-1 or bit 0, with no repeated end state.
REQ-027 COUNT step: led = led+1 modulo 2^NLED; all ones wraps to 0.
REQ-028 In HOLD: led, prescaler, direction and mode are frozen and step_tick=0. On resume, counting continues from the held prescaler value.
REQ-029 A mode load at a step edge SHALL take precedence: no advance, no step_tick.

Reset
REQ-030 rst=1 at an edge SHALL force, in the next cycle: state IDLE, mode 0, led 0, prescaler 0, direction up, mode_ack 0, step_tick 0, busy 0, req-edge register 0.
REQ-031 Reset asserted mid-operation SHALL behave identically to reset from power-up, and SHALL override every simultaneous input.

Verification (TICK_DIV=4, NLED=6)
REQ-032 Pulse mode_req with mode_sel=1, then run=1 -> mode_ack is a one-cycle pulse. led=01 at the run edge, then 02,04,08,10,20,01, one step every 4 cycles, each with a one-cycle step_tick.
REQ-033 Mode 2 with run=1 -> led 01,02,04,08,10,20,10,08,04,02,01,02, with no repeated end state.
REQ-034 Mode 3 with run=1 for 65 steps -> led counts 00..3F, wraps to 00, then 01; step_tick period is 4 cycles.
REQ-035 Drop run for 10 cycles mid-period with prescaler=2 -> led frozen and no step_tick. After run=1, the next step occurs 2 cycles later.
REQ-036 In RUN, assert stop and a mode_req edge together -> IDLE, led=00, busy=0, no mode_ack, mode unchanged. Holding mode_req high for 5 cycles yields exactly one mode_ack.
REQ-037 Assert rst mid-RUN with led=08 in mode 2 -> next cycle led=00, busy=0, mode=0. A later run=1 starts ALL_BLINK with led=3F.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if
// Purpose: bundles the control inputs, pattern outputs and debug view of
//          led_pattern_sequencer into one port.
// Signals:
//   run        level enable (1 = advance pattern, 0 = hold)
//   stop       one-cycle pulse, returns the sequencer to IDLE
//   mode_req   mode load request, only its rising edge is acted on
//   mode_sel   requested mode, sampled in the accepting cycle
//   mode_ack   one-cycle pulse in the cycle after an accepted request
//   led        registered LED drive, bit 0 = LED0
//   step_tick  one-cycle pulse in the first cycle a stepped pattern is shown
//   busy       1 whenever the sequencer is not in IDLE
//   dbg_state  current FSM state: 0 IDLE, 1 RUN, 2 HOLD
//   dbg_mode   currently stored mode
//
// Handshake: mode_req/mode_ack is an edge-request / pulse-acknowledge pair.
// The request is taken in any cycle where mode_req is 1 and was 0 in the
// previous cycle, unless stop is also high. mode_sel must be stable in that
// cycle. mode_ack is high for exactly the next cycle. Holding mode_req high
// produces no further requests until it has been low for at least one cycle.
interface led_pattern_sequencer_if #(
    parameter int NLED = 6
);
    logic            run;
    logic            stop;
    logic            mode_req;
    logic [1:0]      mode_sel;
    logic            mode_ack;
    logic [NLED-1:0] led;
    logic            step_tick;
    logic            busy;
    logic [1:0]      dbg_state;
    logic [1:0]      dbg_mode;

    modport master (
        output run, stop, mode_req, mode_sel,
        input  mode_ack, led, step_tick, busy, dbg_state, dbg_mode
    );

    modport slave (
        input  run, stop, mode_req, mode_sel,
        output mode_ack, led, step_tick, busy, dbg_state, dbg_mode
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Purpose: drives NLED LEDs with one of four patterns (ALL_BLINK, CHASE,
//          BOUNCE, COUNT), advancing one step every TICK_DIV clock cycles
//          while running. The pattern can be held, stopped, or switched by
//          a mode request.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  led_pattern_sequencer_if slave modport (controls, LEDs, debug)
module led_pattern_sequencer #(
    parameter int TICK_DIV = 12500000,
    parameter int NLED     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    led_pattern_sequencer_if.slave bus
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [NLED-1:0] ONE_HOT0   = NLED'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [NLED-1:0] led_q, led_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_up_q, dir_up_d;
    logic            req_prev_q, req_prev_d;
    logic            ack_q, ack_d;
    logic            tick_q, tick_d;

    logic            req_edge;
    logic            load;

    function automatic logic [NLED-1:0] start_pattern(input logic [1:0] m);
        case (m)
            2'd0:    return '1;
            2'd3:    return '0;
            default: return ONE_HOT0;
        endcase
    endfunction

    assign req_edge = bus.mode_req & ~req_prev_q;
    // stop outranks a mode load in the same cycle.
    assign load     = req_edge & ~bus.stop;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        led_d      = led_q;
        presc_d    = presc_q;
        dir_up_d   = dir_up_q;
        req_prev_d = bus.mode_req;
        ack_d      = load;
        tick_d     = 1'b0;

        if (load) begin
            mode_d = bus.mode_sel;
        end

        if (bus.stop) begin
            state_d  = ST_IDLE;
            led_d    = '0;
            presc_d  = '0;
            dir_up_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d    = '0;
                    presc_d  = '0;
                    dir_up_d = 1'b1;
                    // mode_d already carries a coincident load.
                    if (bus.run) begin
                        state_d = ST_RUN;
                        led_d   = start_pattern(mode_d);
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (load) begin
                        // A load restarts the pattern and wins over a step
                        // edge; the state does not change in this cycle.
                        led_d    = start_pattern(mode_d);
                        presc_d  = '0;
                        dir_up_d = 1'b1;
                    end else if (state_q == ST_HOLD) begin
                        if (bus.run) begin
                            state_d = ST_RUN;
                        end
                    end else if (!bus.run) begin
                        state_d = ST_HOLD;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        case (mode_q)
                            2'd0: led_d = ~led_q;
                            2'd1: led_d = {led_q[NLED-2:0], led_q[NLED-1]};
                            2'd2: begin
                                // Flip direction as the lit bit lands on an
                                // end so the end pattern is never repeated.
                                if (dir_up_q) begin
                                    led_d = led_q << 1;
                                    if (led_q[NLED-2]) dir_up_d = 1'b0;
                                end else begin
                                    led_d = led_q >> 1;
                                    if (led_q[1]) dir_up_d = 1'b1;
                                end
                            end
                            default: led_d = led_q + ONE_HOT0;
                        endcase
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            led_q      <= '0;
            presc_q    <= '0;
            dir_up_q   <= 1'b1;
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            presc_q    <= presc_d;
            dir_up_q   <= dir_up_d;
            req_prev_q <= req_prev_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.led       = led_q;
    assign bus.mode_ack  = ack_q;
    assign bus.step_tick = tick_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;
    assign bus.dbg_mode  = mode_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Purpose: self-checking bench for led_pattern_sequencer (TICK_DIV=4,
//          NLED=6). A driver applies one input vector per cycle and pushes
//          the reference model's expected outputs; a monitor pops and
//          compares after every rising edge.
module tb_led_pattern_sequencer;
    localparam int TICK = 4;
    localparam int NLED = 6;
    localparam int W    = 7 + NLED;

    logic clk;
    logic rst;

    led_pattern_sequencer_if #(.NLED(NLED)) bus ();

    led_pattern_sequencer #(.TICK_DIV(TICK), .NLED(NLED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: state 0 IDLE / 1 RUN / 2 HOLD, the pattern is a pure
    // function of the mode and the number of steps since it (re)started.
    int m_state = 0;
    int m_mode  = 0;
    int m_k     = 0;
    int m_phase = 0;
    bit m_prev  = 1'b0;

    function automatic logic [NLED-1:0] pattern(input int mode, input int k);
        int per;
        int p;
        per = 2 * (NLED - 1);
        case (mode)
            0: return (k % 2 == 0) ? {NLED{1'b1}} : {NLED{1'b0}};
            1: return NLED'(1) << (k % NLED);
            2: begin
                p = k % per;
                if (p >= NLED) p = per - p;
                return NLED'(1) << p;
            end
            default: return NLED'(k % (1 << NLED));
        endcase
    endfunction

    task automatic drive(input bit r, input bit rn, input bit st,
                         input bit rq, input logic [1:0] sel);
        bit ack;
        bit tick;
        bit edge_seen;
        logic [NLED-1:0] exp_led;
        @(negedge clk);
        rst          = r;
        bus.run      = rn;
        bus.stop     = st;
        bus.mode_req = rq;
        bus.mode_sel = sel;
        ack  = 1'b0;
        tick = 1'b0;
        if (r) begin
            m_state = 0; m_mode = 0; m_k = 0; m_phase = 0; m_prev = 1'b0;
        end else begin
            edge_seen = rq && !m_prev;
            m_prev    = rq;
            if (st) begin
                m_state = 0; m_k = 0; m_phase = 0;
            end else if (edge_seen) begin
                m_mode = int'(sel);
                ack    = 1'b1;
                m_k    = 0;
                m_phase = 0;
                if (m_state == 0 && rn) m_state = 1;
            end else begin
                case (m_state)
                    0: if (rn) begin m_state = 1; m_k = 0; m_phase = 0; end
                    1: begin
                        if (!rn) m_state = 2;
                        else begin
                            m_phase++;
                            if (m_phase == TICK) begin
                                m_phase = 0; m_k++; tick = 1'b1;
                            end
                        end
                    end
                    default: if (rn) m_state = 1;
                endcase
            end
        end
        exp_led = (m_state == 0) ? '0 : pattern(m_mode, m_k);
        exp_q.push_back({2'(m_state), 2'(m_mode), (m_state != 0), ack, tick, exp_led});
    endtask

    task automatic idle_cycles(input int n, input bit rn);
        for (int i = 0; i < n; i++) drive(1'b0, rn, 1'b0, 1'b0, 2'd0);
    endtask

    // Monitor: one expected record per cycle, compared just after the edge.
    always begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.dbg_state, bus.dbg_mode, bus.busy, bus.mode_ack,
                 bus.step_tick, bus.led};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got state=%0d mode=%0d busy=%0b ack=%0b tick=%0b led=%h, expected state=%0d mode=%0d busy=%0b ack=%0b tick=%0b led=%h",
                         $time, a[W-1:W-2], a[W-3:W-4], a[W-5], a[W-6], a[W-7], a[NLED-1:0],
                         e[W-1:W-2], e[W-3:W-4], e[W-5], e[W-6], e[W-7], e[NLED-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.run      = 1'b0;
        bus.stop     = 1'b0;
        bus.mode_req = 1'b0;
        bus.mode_sel = 2'd0;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        idle_cycles(3, 1'b0);

        // CHASE: load in IDLE, then run through a full rotation.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        idle_cycles(30, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // BOUNCE: two full sweeps.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        idle_cycles(50, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

        // COUNT: reach prescaler=2, hold 10 cycles, resume, run past wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        idle_cycles(2, 1'b1);
        idle_cycles(10, 1'b0);
        idle_cycles(270, 1'b1);

        // stop with a coincident request edge: no load, no ack.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        idle_cycles(3, 1'b0);
        // Request held high for 5 cycles: exactly one ack.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        idle_cycles(14, 1'b1);

        // Reset mid-run overrides every other input.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle_cycles(12, 1'b1);

        // Load while running, including near step edges.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        idle_cycles(3, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

        // Randomized operation.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 6) == 0),
                  2'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked records, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
